// File: rtl/pipelined_cache_control_if.sv
// rtl/pipelined_cache_control_if.sv - CPU/array/physical-memory signal bundle of the cache controller
interface pipelined_cache_control_if #(
    parameter int CNT_W = 32
);
    logic             cpu_read;
    logic             cpu_write;
    logic             s2_hit;
    logic             s2_hit1;
    logic             s2_dirty;
    logic             s2_lru;
    logic             s2_write;
    logic             pmem_resp;
    logic             load_regs;
    logic             addr_sel;
    logic             mem_resp;
    logic             data_we;
    logic             data_fill;
    logic             tag_we;
    logic             dirty_set;
    logic             dirty_clr;
    logic             lru_we;
    logic             lru_val;
    logic             way_sel;
    logic             pmem_read;
    logic             pmem_write;
    logic             pmem_addr_sel;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        input  cpu_read, cpu_write, s2_hit, s2_hit1, s2_dirty, s2_lru, s2_write, pmem_resp,
        output load_regs, addr_sel, mem_resp, data_we, data_fill, tag_we, dirty_set, dirty_clr,
               lru_we, lru_val, way_sel, pmem_read, pmem_write, pmem_addr_sel, hit_count, miss_count
    );

    modport slave (
        output cpu_read, cpu_write, s2_hit, s2_hit1, s2_dirty, s2_lru, s2_write, pmem_resp,
        input  load_regs, addr_sel, mem_resp, data_we, data_fill, tag_we, dirty_set, dirty_clr,
               lru_we, lru_val, way_sel, pmem_read, pmem_write, pmem_addr_sel, hit_count, miss_count
    );
endinterface

// File: rtl/pipelined_cache_control.sv
// rtl/pipelined_cache_control.sv - stall/miss sequencing controller of the two-stage pipelined cache
module pipelined_cache_control #(
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    pipelined_cache_control_if.master bus
);
    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        REPLAY    = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             s2_valid_q;
    logic [CNT_W-1:0] hit_q;
    logic [CNT_W-1:0] miss_q;

    logic load_regs;
    logic addr_sel;
    logic mem_resp;
    logic data_we;
    logic data_fill;
    logic tag_we;
    logic dirty_set;
    logic dirty_clr;
    logic lru_we;
    logic lru_val;
    logic way_sel;
    logic pmem_read;
    logic pmem_write;
    logic pmem_addr_sel;
    logic hit_evt;
    logic miss_evt;

    // Lookup outcome of a live stage-2 request while the pipeline is flowing.
    assign hit_evt  = !rst && (state_q == NORMAL) && s2_valid_q && bus.s2_hit;
    assign miss_evt = !rst && (state_q == NORMAL) && s2_valid_q && !bus.s2_hit;

    // Sequencer state register; reset abandons any memory transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage-2 occupancy follows the stage register only when it advances in NORMAL;
    // REPLAY reloads the same request, so occupancy is kept as-is there.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
        end else if ((state_q == NORMAL) && load_regs) begin
            s2_valid_q <= bus.cpu_read | bus.cpu_write;
        end
    end

    // Saturating hit/miss performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (hit_evt && (hit_q != {CNT_W{1'b1}})) begin
                hit_q <= hit_q + 1'b1;
            end
            if (miss_evt && (miss_q != {CNT_W{1'b1}})) begin
                miss_q <= miss_q + 1'b1;
            end
        end
    end

    // Next state and control strobes; everything idles to the reset pattern while rst is high.
    always_comb begin
        state_d       = state_q;
        load_regs     = 1'b0;
        addr_sel      = 1'b0;
        mem_resp      = 1'b0;
        data_we       = 1'b0;
        data_fill     = 1'b0;
        tag_we        = 1'b0;
        dirty_set     = 1'b0;
        dirty_clr     = 1'b0;
        lru_we        = 1'b0;
        lru_val       = 1'b0;
        way_sel       = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        if (rst) begin
            state_d   = NORMAL;
            load_regs = 1'b1;
        end else begin
            unique case (state_q)
                NORMAL: begin
                    if (!s2_valid_q) begin
                        load_regs = 1'b1;
                    end else if (bus.s2_hit) begin
                        load_regs = 1'b1;
                        mem_resp  = 1'b1;
                        lru_we    = 1'b1;
                        lru_val   = ~bus.s2_hit1;
                        way_sel   = bus.s2_hit1;
                        if (bus.s2_write) begin
                            data_we   = 1'b1;
                            dirty_set = 1'b1;
                        end
                    end else begin
                        addr_sel = 1'b1;
                        state_d  = bus.s2_dirty ? WRITEBACK : FETCH;
                    end
                end
                WRITEBACK: begin
                    addr_sel      = 1'b1;
                    way_sel       = bus.s2_lru;
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    if (bus.pmem_resp) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    addr_sel  = 1'b1;
                    way_sel   = bus.s2_lru;
                    pmem_read = 1'b1;
                    if (bus.pmem_resp) begin
                        data_we   = 1'b1;
                        data_fill = 1'b1;
                        tag_we    = 1'b1;
                        dirty_clr = 1'b1;
                        state_d   = REPLAY;
                    end
                end
                REPLAY: begin
                    load_regs = 1'b1;
                    addr_sel  = 1'b1;
                    state_d   = NORMAL;
                end
                default: begin
                    state_d = NORMAL;
                end
            endcase
        end
    end

    assign bus.load_regs     = load_regs;
    assign bus.addr_sel      = addr_sel;
    assign bus.mem_resp      = mem_resp;
    assign bus.data_we       = data_we;
    assign bus.data_fill     = data_fill;
    assign bus.tag_we        = tag_we;
    assign bus.dirty_set     = dirty_set;
    assign bus.dirty_clr     = dirty_clr;
    assign bus.lru_we        = lru_we;
    assign bus.lru_val       = lru_val;
    assign bus.way_sel       = way_sel;
    assign bus.pmem_read     = pmem_read;
    assign bus.pmem_write    = pmem_write;
    assign bus.pmem_addr_sel = pmem_addr_sel;
    assign bus.hit_count     = hit_q;
    assign bus.miss_count    = miss_q;
endmodule

// File: tb/tb_pipelined_cache_control.sv
// tb/tb_pipelined_cache_control.sv - self-checking bench for pipelined_cache_control
module tb_pipelined_cache_control;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   resp_seen;

    pipelined_cache_control_if #(.CNT_W(CNT_W)) bus ();

    pipelined_cache_control #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    // Transaction view: is a request sitting in stage 2, is a miss being serviced,
    // does the serviced line still owe a write-back, is the lookup being re-run.
    bit m_valid;
    bit m_missing;
    bit m_owes_wb;
    bit m_rerun;
    int m_hits;
    int m_misses;

    function automatic logic [13:0] expect_ctl();
        logic ld, as, rsp, dwe, dfl, twe, dset, dclr, lwe, lval, way, prd, pwr, pas;
        ld = 0; as = 0; rsp = 0; dwe = 0; dfl = 0; twe = 0; dset = 0; dclr = 0;
        lwe = 0; lval = 0; way = 0; prd = 0; pwr = 0; pas = 0;
        if (rst) begin
            ld = 1;
        end else if (m_rerun) begin
            ld = 1; as = 1;
        end else if (m_missing) begin
            as  = 1;
            way = bus.s2_lru;
            if (m_owes_wb) begin
                pwr = 1; pas = 1;
            end else begin
                prd = 1;
                if (bus.pmem_resp) begin
                    dwe = 1; dfl = 1; twe = 1; dclr = 1;
                end
            end
        end else if (!m_valid) begin
            ld = 1;
        end else if (bus.s2_hit) begin
            ld = 1; rsp = 1; lwe = 1; lval = !bus.s2_hit1; way = bus.s2_hit1;
            if (bus.s2_write) begin
                dwe = 1; dset = 1;
            end
        end else begin
            as = 1;
        end
        return {ld, as, rsp, dwe, dfl, twe, dset, dclr, lwe, lval, way, prd, pwr, pas};
    endfunction

    // Per-cycle comparison at the falling edge, model advance at the rising edge.
    initial begin
        logic [13:0] exp_v;
        logic [13:0] got_v;
        m_valid = 0; m_missing = 0; m_owes_wb = 0; m_rerun = 0; m_hits = 0; m_misses = 0;
        forever begin
            @(negedge clk);
            exp_v = expect_ctl();
            got_v = {bus.load_regs, bus.addr_sel, bus.mem_resp, bus.data_we, bus.data_fill,
                     bus.tag_we, bus.dirty_set, bus.dirty_clr, bus.lru_we, bus.lru_val,
                     bus.way_sel, bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL ctl_outputs @%0t: got %b expected %b", $time, got_v, exp_v);
            end
            tests++;
            if (bus.hit_count !== CNT_W'(m_hits) || bus.miss_count !== CNT_W'(m_misses)) begin
                fails++;
                $display("FAIL counters @%0t: got hit=%0d miss=%0d expected hit=%0d miss=%0d",
                         $time, bus.hit_count, bus.miss_count, m_hits, m_misses);
            end
            if (bus.mem_resp === 1'b1) resp_seen++;
            @(posedge clk);
            if (rst) begin
                m_valid = 0; m_missing = 0; m_owes_wb = 0; m_rerun = 0; m_hits = 0; m_misses = 0;
            end else if (m_rerun) begin
                m_rerun = 0;
            end else if (m_missing) begin
                if (bus.pmem_resp) begin
                    if (m_owes_wb) begin
                        m_owes_wb = 0;
                    end else begin
                        m_missing = 0;
                        m_rerun   = 1;
                    end
                end
            end else if (m_valid && !bus.s2_hit) begin
                m_misses  = (m_misses < 15) ? m_misses + 1 : m_misses;
                m_missing = 1;
                m_owes_wb = bus.s2_dirty;
            end else begin
                if (m_valid) m_hits = (m_hits < 15) ? m_hits + 1 : m_hits;
                m_valid = bus.cpu_read | bus.cpu_write;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp_val);
        tests++;
        if (act != exp_val) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_val);
        end
    endtask

    task automatic idle_inputs();
        bus.cpu_read = 0; bus.cpu_write = 0; bus.s2_hit = 0; bus.s2_hit1 = 0;
        bus.s2_dirty = 0; bus.s2_lru = 0; bus.s2_write = 0; bus.pmem_resp = 0;
    endtask

    initial begin
        int k;
        int r0;
        tests = 0; fails = 0; resp_seen = 0;
        rst = 1;
        idle_inputs();
        repeat (2) cyc();
        #2;
        chk("reset_load_regs", bus.load_regs, 1);
        chk("reset_addr_sel", bus.addr_sel, 0);
        chk("reset_pmem_read", bus.pmem_read, 0);
        chk("reset_hit_count", int'(bus.hit_count), 0);
        cyc();
        rst = 0;

        // clean miss to a cold set, victim way 1
        cyc(); bus.cpu_read = 1;
        cyc(); bus.cpu_read = 0; bus.s2_hit = 0; bus.s2_dirty = 0; bus.s2_lru = 1;
        #2; chk("miss_stall_load_regs", bus.load_regs, 0);
        cyc(); #2; chk("fetch_pmem_read", bus.pmem_read, 1);
        cyc(); cyc();
        bus.pmem_resp = 1;
        #2;
        chk("fill_data_we", bus.data_we, 1);
        chk("fill_tag_we", bus.tag_we, 1);
        chk("fill_way_sel", bus.way_sel, 1);
        chk("fill_data_fill", bus.data_fill, 1);
        cyc(); bus.pmem_resp = 0; bus.s2_hit = 1; bus.s2_hit1 = 1;
        k = 1;
        #2;
        while (bus.mem_resp !== 1'b1 && k < 6) begin
            cyc(); k++; #2;
        end
        chk("miss_resp_latency", k, 2);
        cyc(); bus.s2_hit = 0;
        cyc(); #2;
        chk("miss_hit_count", int'(bus.hit_count), 1);
        chk("miss_miss_count", int'(bus.miss_count), 1);

        // write hit in way 1 followed by read hit
        idle_inputs();
        cyc(); bus.cpu_write = 1;
        cyc(); bus.cpu_write = 0; bus.cpu_read = 1; bus.s2_hit = 1; bus.s2_hit1 = 1; bus.s2_write = 1;
        #2;
        chk("whit_mem_resp", bus.mem_resp, 1);
        chk("whit_data_we", bus.data_we, 1);
        chk("whit_dirty_set", bus.dirty_set, 1);
        chk("whit_lru_val", bus.lru_val, 0);
        cyc(); bus.cpu_read = 0; bus.s2_hit1 = 0; bus.s2_write = 0;
        #2;
        chk("rhit_mem_resp", bus.mem_resp, 1);
        chk("rhit_data_we", bus.data_we, 0);
        chk("rhit_lru_val", bus.lru_val, 1);
        cyc(); bus.s2_hit = 0;
        #2; chk("after_hits_mem_resp", bus.mem_resp, 0);

        // dirty miss: write-back then fetch
        r0 = resp_seen;
        cyc(); bus.cpu_read = 1;
        cyc(); bus.cpu_read = 0; bus.s2_hit = 0; bus.s2_dirty = 1; bus.s2_lru = 0;
        cyc(); #2;
        chk("wb_pmem_write", bus.pmem_write, 1);
        chk("wb_addr_sel", bus.pmem_addr_sel, 1);
        chk("wb_load_regs", bus.load_regs, 0);
        chk("wb_no_read", bus.pmem_read, 0);
        cyc(); cyc(); bus.pmem_resp = 1;
        cyc(); bus.pmem_resp = 0; bus.s2_dirty = 0;
        #2;
        chk("fetch_after_wb_read", bus.pmem_read, 1);
        chk("fetch_after_wb_write", bus.pmem_write, 0);
        chk("fetch_after_wb_addr", bus.pmem_addr_sel, 0);
        chk("fetch_after_wb_load", bus.load_regs, 0);
        cyc(); bus.pmem_resp = 1;
        cyc(); bus.pmem_resp = 0; bus.s2_hit = 1; bus.s2_hit1 = 0;
        cyc(); cyc(); bus.s2_hit = 0;
        cyc(); cyc(); #2;
        chk("dirty_miss_resp_count", resp_seen - r0, 1);
        chk("dirty_miss_count", int'(bus.miss_count), 2);
        chk("dirty_hit_count", int'(bus.hit_count), 4);

        // spurious pmem_resp while idle
        idle_inputs();
        cyc(); bus.pmem_resp = 1;
        #2;
        chk("spur_data_we", bus.data_we, 0);
        chk("spur_tag_we", bus.tag_we, 0);
        chk("spur_load_regs", bus.load_regs, 1);
        cyc(); bus.pmem_resp = 0;
        cyc(); #2;
        chk("spur_hit_count", int'(bus.hit_count), 4);
        chk("spur_miss_count", int'(bus.miss_count), 2);

        // reset during FETCH
        cyc(); bus.cpu_read = 1;
        cyc(); bus.cpu_read = 0; bus.s2_hit = 0; bus.s2_dirty = 0; bus.s2_lru = 1;
        cyc(); #2; chk("pre_rst_pmem_read", bus.pmem_read, 1);
        cyc(); rst = 1; bus.pmem_resp = 1;
        #2; chk("rst_no_fill", bus.data_we, 0);
        cyc(); rst = 0; bus.pmem_resp = 0;
        #2;
        chk("post_rst_pmem_read", bus.pmem_read, 0);
        chk("post_rst_load_regs", bus.load_regs, 1);
        chk("post_rst_miss_count", int'(bus.miss_count), 0);
        cyc(); #2; chk("post_rst_no_miss", int'(bus.miss_count), 0);
        bus.cpu_read = 1;
        cyc(); bus.cpu_read = 0; bus.s2_hit = 1; bus.s2_hit1 = 0;
        #2; chk("post_rst_read_resp", bus.mem_resp, 1);
        cyc(); bus.s2_hit = 0;
        cyc(); #2; chk("post_rst_hit_count", int'(bus.hit_count), 1);

        // counter saturation with back-to-back hits
        rst = 1;
        cyc(); rst = 0;
        bus.cpu_read = 1; bus.s2_hit = 1;
        repeat (22) cyc();
        bus.cpu_read = 0;
        cyc(); bus.s2_hit = 0;
        cyc(); cyc(); #2;
        chk("sat_hit_count", int'(bus.hit_count), 15);
        chk("sat_miss_count", int'(bus.miss_count), 0);

        idle_inputs();
        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
